// File: rtl/cacode_pkg.sv
// Shared constants, configuration payload and chip-combining helper for the
// GPS L1 C/A code generator.
package cacode_pkg;

    localparam int unsigned CA_LEN  = 1023;
    localparam int unsigned LFSR_W  = 10;
    localparam int unsigned TAP_W   = 4;
    localparam int unsigned OMEGA_W = 16;

    // Feedback masks: G1 = x^3+x^10, G2 = x^2+x^3+x^6+x^8+x^9+x^10 (bit i = stage i+1)
    localparam logic [LFSR_W-1:0] G1_FB     = 10'h204;
    localparam logic [LFSR_W-1:0] G2_FB     = 10'h3A6;
    localparam logic [LFSR_W-1:0] LFSR_SEED = 10'h3FF;
    localparam logic [TAP_W-1:0]  T0_DEF    = 4'd2;
    localparam logic [TAP_W-1:0]  T1_DEF    = 4'd6;
    localparam logic [LFSR_W-1:0] IDX_MAX   = LFSR_W'(CA_LEN - 1);

    typedef struct packed {
        logic               en;
        logic [LFSR_W-1:0]  g1;
        logic [LFSR_W-1:0]  g2;
        logic [TAP_W-1:0]   t0;
        logic [TAP_W-1:0]   t1;
        logic [OMEGA_W-1:0] omega;
        logic [LFSR_W-1:0]  idx;
    } chan_cfg_t;

    localparam chan_cfg_t CFG_RST = '{en: 1'b0, g1: LFSR_SEED, g2: LFSR_SEED,
                                      t0: T0_DEF, t1: T1_DEF, omega: '0, idx: '0};

    function automatic logic ca_chip(input logic [LFSR_W-1:0] g1,
                                     input logic [LFSR_W-1:0] g2,
                                     input logic [TAP_W-1:0]  t0,
                                     input logic [TAP_W-1:0]  t1);
        logic [TAP_W-1:0] a;
        logic [TAP_W-1:0] b;
        a = t0 - 4'd1;
        b = t1 - 4'd1;
        return g1[LFSR_W-1] ^ g2[a] ^ g2[b];
    endfunction

endpackage

// File: rtl/cacode_nco_chan.sv
// One C/A code channel: NCO chip clock, G1/G2 LFSRs, code-phase counter,
// E/P/L delay line and a shadow config that waits for the sync strobe.
module cacode_nco_chan
    import cacode_pkg::*;
#(
    parameter int unsigned NCO_W = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_i,
    input  logic              dfr_i,
    input  logic              sync_i,
    input  chan_cfg_t         cfg_i,
    output logic              pending_o,
    output logic              chip_stb_o,
    output logic              chip_e_o,
    output logic              chip_p_o,
    output logic              chip_l_o,
    output logic              epoch_o,
    output logic [LFSR_W-1:0] idx_o
);

    chan_cfg_t        act_q, act_d, shadow_q, shadow_d;
    logic [NCO_W-1:0] acc_q, acc_d;
    logic [2:0]       epl_q, epl_d;
    logic             stb_q, stb_d, epoch_q, epoch_d, pend_q, pend_d;
    logic             apply_sync;
    logic [NCO_W:0]   sum;

    if (NCO_W < OMEGA_W) begin : g_omega_pad
        logic omega_unused;
        assign omega_unused = ^act_q.omega[OMEGA_W-1:NCO_W];
    end

    // Load (immediate or sync-applied) takes priority over a coincident carry
    always_comb begin
        act_d      = act_q;
        shadow_d   = shadow_q;
        acc_d      = acc_q;
        epl_d      = epl_q;
        pend_d     = pend_q;
        stb_d      = 1'b0;
        epoch_d    = 1'b0;
        apply_sync = sync_i && pend_q;
        sum        = {1'b0, acc_q} + {1'b0, act_q.omega[NCO_W-1:0]};

        if (dfr_i) begin
            shadow_d = cfg_i;
            pend_d   = 1'b1;
        end else if (apply_sync) begin
            pend_d = 1'b0;
        end

        if (ld_i || apply_sync) begin
            act_d = ld_i ? cfg_i : shadow_q;
            acc_d = '0;
            epl_d = '0;
        end else if (act_q.en) begin
            acc_d = sum[NCO_W-1:0];
            if (sum[NCO_W]) begin
                epl_d     = {epl_q[1:0], ca_chip(act_q.g1, act_q.g2, act_q.t0, act_q.t1)};
                act_d.g1  = {act_q.g1[LFSR_W-2:0], ^(act_q.g1 & G1_FB)};
                act_d.g2  = {act_q.g2[LFSR_W-2:0], ^(act_q.g2 & G2_FB)};
                act_d.idx = (act_q.idx == IDX_MAX) ? '0 : act_q.idx + 10'd1;
                stb_d     = 1'b1;
                epoch_d   = (act_q.idx == IDX_MAX);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            act_q    <= CFG_RST;
            shadow_q <= CFG_RST;
            acc_q    <= '0;
            epl_q    <= '0;
            pend_q   <= 1'b0;
            stb_q    <= 1'b0;
            epoch_q  <= 1'b0;
        end else begin
            act_q    <= act_d;
            shadow_q <= shadow_d;
            acc_q    <= acc_d;
            epl_q    <= epl_d;
            pend_q   <= pend_d;
            stb_q    <= stb_d;
            epoch_q  <= epoch_d;
        end
    end

    assign pending_o  = pend_q;
    assign chip_stb_o = stb_q;
    assign chip_e_o   = epl_q[0];
    assign chip_p_o   = epl_q[1];
    assign chip_l_o   = epl_q[2];
    assign epoch_o    = epoch_q;
    assign idx_o      = act_q.idx;

endmodule

// File: rtl/cacode_nco_multi.sv
// Multi-channel GPS L1 C/A code generator: shared config port with validation,
// immediate or sync-deferred loads, and one code channel per instance.
module cacode_nco_multi
    import cacode_pkg::*;
#(
    parameter  int unsigned NUM_CH = 4,
    parameter  int unsigned NCO_W  = 9,
    localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cfg_valid,
    output logic                       cfg_ready,
    input  logic [CH_W-1:0]            cfg_ch,
    input  logic                       cfg_defer,
    input  logic                       cfg_en,
    input  logic [LFSR_W-1:0]          cfg_g1,
    input  logic [LFSR_W-1:0]          cfg_g2,
    input  logic [TAP_W-1:0]           cfg_t0,
    input  logic [TAP_W-1:0]           cfg_t1,
    input  logic [NCO_W-1:0]           cfg_omega,
    input  logic [LFSR_W-1:0]          cfg_idx,
    output logic                       cfg_err,
    input  logic                       sync_in,
    output logic [NUM_CH-1:0]          chip_stb,
    output logic [NUM_CH-1:0]          chip_e,
    output logic [NUM_CH-1:0]          chip_p,
    output logic [NUM_CH-1:0]          chip_l,
    output logic [NUM_CH-1:0]          epoch,
    output logic [NUM_CH*LFSR_W-1:0]   code_idx
);

    localparam int unsigned CHX_W = CH_W + 1;

    chan_cfg_t         cfg_s;
    logic [NUM_CH-1:0] pending, ld, dfr;
    logic              ch_ok, fields_ok, xfer, err_d, err_q;

    // Request decode; bad taps, bad phase or a nonexistent channel are rejected
    always_comb begin
        cfg_s       = CFG_RST;
        cfg_s.en    = cfg_en;
        cfg_s.g1    = cfg_g1;
        cfg_s.g2    = cfg_g2;
        cfg_s.t0    = cfg_t0;
        cfg_s.t1    = cfg_t1;
        cfg_s.omega = OMEGA_W'(cfg_omega);
        cfg_s.idx   = cfg_idx;
        ld          = '0;
        dfr         = '0;
        ch_ok       = ({1'b0, cfg_ch} < CHX_W'(NUM_CH));
        cfg_ready   = rst && (!ch_ok || !pending[cfg_ch]);
        fields_ok   = ch_ok
                   && (cfg_t0 >= 4'd1) && (cfg_t0 <= 4'd10)
                   && (cfg_t1 >= 4'd1) && (cfg_t1 <= 4'd10)
                   && (cfg_t0 != cfg_t1)
                   && (cfg_idx <= IDX_MAX);
        xfer        = cfg_valid && cfg_ready;
        err_d       = xfer && !fields_ok;
        for (int i = 0; i < NUM_CH; i++) begin
            ld[i]  = xfer && fields_ok && !cfg_defer && (cfg_ch == CH_W'(i));
            dfr[i] = xfer && fields_ok &&  cfg_defer && (cfg_ch == CH_W'(i));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign cfg_err = err_q;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
        cacode_nco_chan #(.NCO_W(NCO_W)) u_chan (
            .clk        (clk),
            .rst        (rst),
            .ld_i       (ld[g]),
            .dfr_i      (dfr[g]),
            .sync_i     (sync_in),
            .cfg_i      (cfg_s),
            .pending_o  (pending[g]),
            .chip_stb_o (chip_stb[g]),
            .chip_e_o   (chip_e[g]),
            .chip_p_o   (chip_p[g]),
            .chip_l_o   (chip_l[g]),
            .epoch_o    (epoch[g]),
            .idx_o      (code_idx[g*LFSR_W +: LFSR_W])
        );
    end

endmodule

// File: tb/tb_cacode_nco_multi.sv
// Directed self-checking bench for the multi-channel C/A code generator.
module tb_cacode_nco_multi;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned NCO_W  = 9;
    localparam int unsigned CH_W   = 2;

    logic                 clk, rst;
    logic                 cfg_valid, cfg_ready, cfg_defer, cfg_en, cfg_err, sync_in;
    logic [CH_W-1:0]      cfg_ch;
    logic [9:0]           cfg_g1, cfg_g2, cfg_idx;
    logic [3:0]           cfg_t0, cfg_t1;
    logic [NCO_W-1:0]     cfg_omega;
    logic [NUM_CH-1:0]    chip_stb, chip_e, chip_p, chip_l, epoch;
    logic [NUM_CH*10-1:0] code_idx;

    int checks = 0;
    int passes = 0;
    logic [9:0] prn1_seq = 10'b1100100000;

    cacode_nco_multi #(.NUM_CH(NUM_CH), .NCO_W(NCO_W)) dut (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_ch(cfg_ch), .cfg_defer(cfg_defer), .cfg_en(cfg_en), .cfg_g1(cfg_g1),
        .cfg_g2(cfg_g2), .cfg_t0(cfg_t0), .cfg_t1(cfg_t1), .cfg_omega(cfg_omega),
        .cfg_idx(cfg_idx), .cfg_err(cfg_err), .sync_in(sync_in), .chip_stb(chip_stb),
        .chip_e(chip_e), .chip_p(chip_p), .chip_l(chip_l), .epoch(epoch),
        .code_idx(code_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_cfg(input int ch, input logic defer, input logic en,
                             input logic [9:0] g1, input logic [9:0] g2,
                             input logic [3:0] t0, input logic [3:0] t1,
                             input logic [NCO_W-1:0] omega, input logic [9:0] idx);
        cfg_valid = 1'b1;
        cfg_ch    = CH_W'(ch);
        cfg_defer = defer;
        cfg_en    = en;
        cfg_g1    = g1;
        cfg_g2    = g2;
        cfg_t0    = t0;
        cfg_t1    = t1;
        cfg_omega = omega;
        cfg_idx   = idx;
    endtask

    function automatic logic [9:0] idx_of(input logic [NUM_CH*10-1:0] v, input int ch);
        return v[ch*10 +: 10];
    endfunction

    task automatic test_reset();
        #3;
        checks++; if (chip_stb !== 4'h0 || code_idx !== '0) $display("FAIL reset_outputs stb=%h idx=%h exp 0", chip_stb, code_idx); else passes++;
        checks++; if (cfg_ready !== 1'b0) $display("FAIL reset_ready got %b exp 0", cfg_ready); else passes++;
        #10 rst = 1'b1;
        tick();
        checks++; if (cfg_ready !== 1'b1) $display("FAIL ready_after_reset got %b exp 1", cfg_ready); else passes++;
        checks++; if (chip_stb !== 4'h0 || cfg_err !== 1'b0 || epoch !== 4'h0) $display("FAIL idle_after_reset stb=%h err=%b ep=%h exp 0", chip_stb, cfg_err, epoch); else passes++;
    endtask

    task automatic test_prn1();
        drive_cfg(0, 1'b0, 1'b1, 10'h3FF, 10'h3FF, 4'd2, 4'd6, 9'd256, 10'd0);
        tick();
        cfg_valid = 1'b0;
        checks++; if (chip_stb[0] !== 1'b0 || idx_of(code_idx, 0) !== 10'd0) $display("FAIL prn1_load stb=%b idx=%0d exp 0/0", chip_stb[0], idx_of(code_idx, 0)); else passes++;
        tick();
        checks++; if (cfg_err !== 1'b0) $display("FAIL prn1_no_err got %b exp 0", cfg_err); else passes++;
        for (int k = 0; k < 10; k++) begin
            logic ep, el;
            ep = (k >= 1) ? prn1_seq[10-k] : 1'b0;
            el = (k >= 2) ? prn1_seq[11-k] : 1'b0;
            if (k > 0) tick();
            checks++; if (chip_stb[0] !== 1'b0) $display("FAIL prn1_gap k=%0d stb=%b exp 0", k, chip_stb[0]); else passes++;
            tick();
            checks++; if (chip_stb[0] !== 1'b1) $display("FAIL prn1_stb k=%0d got %b exp 1", k, chip_stb[0]); else passes++;
            checks++; if ({chip_e[0], chip_p[0], chip_l[0]} !== {prn1_seq[9-k], ep, el}) $display("FAIL prn1_epl k=%0d got %b%b%b exp %b%b%b", k, chip_e[0], chip_p[0], chip_l[0], prn1_seq[9-k], ep, el); else passes++;
            checks++; if (idx_of(code_idx, 0) !== 10'(k + 1)) $display("FAIL prn1_idx k=%0d got %0d exp %0d", k, idx_of(code_idx, 0), k + 1); else passes++;
        end
    endtask

    task automatic test_epoch();
        int ep_cnt = 0;
        int ep_at  = -1;
        drive_cfg(0, 1'b0, 1'b1, 10'h3FF, 10'h3FF, 4'd2, 4'd6, 9'd256, 10'd0);
        tick();
        cfg_valid = 1'b0;
        for (int i = 1; i <= 2046; i++) begin
            tick();
            if (epoch[0] === 1'b1) begin
                ep_cnt++;
                ep_at = i;
            end
        end
        checks++; if (ep_cnt != 1 || ep_at != 2046) $display("FAIL epoch_count got %0d at %0d exp 1 at 2046", ep_cnt, ep_at); else passes++;
        checks++; if (idx_of(code_idx, 0) !== 10'd0 || chip_stb[0] !== 1'b1) $display("FAIL epoch_wrap idx=%0d stb=%b exp 0/1", idx_of(code_idx, 0), chip_stb[0]); else passes++;
        for (int k = 0; k < 4; k++) begin
            tick();
            tick();
            checks++; if (chip_e[0] !== prn1_seq[9-k] || epoch[0] !== 1'b0) $display("FAIL epoch_repeat k=%0d e=%b ep=%b exp %b/0", k, chip_e[0], epoch[0], prn1_seq[9-k]); else passes++;
        end
    endtask

    task automatic test_invalid();
        logic [3:0] t0s [4] = '{4'd0, 4'd4, 4'd2, 4'd11};
        logic [3:0] t1s [4] = '{4'd6, 4'd4, 4'd6, 4'd6};
        logic [9:0] ids [4] = '{10'd0, 10'd0, 10'd1023, 10'd0};
        for (int c = 0; c < 4; c++) begin
            drive_cfg(1, 1'b0, 1'b1, 10'h3FF, 10'h3FF, t0s[c], t1s[c], 9'd256, ids[c]);
            tick();
            cfg_valid = 1'b0;
            checks++; if (cfg_err !== 1'b1) $display("FAIL invalid_err c=%0d got %b exp 1", c, cfg_err); else passes++;
            tick();
            checks++; if (cfg_err !== 1'b0) $display("FAIL invalid_pulse c=%0d got %b exp 0", c, cfg_err); else passes++;
            tick();
            checks++; if (chip_stb[1] !== 1'b0 || idx_of(code_idx, 1) !== 10'd0) $display("FAIL invalid_state c=%0d stb=%b idx=%0d exp 0/0", c, chip_stb[1], idx_of(code_idx, 1)); else passes++;
        end
    endtask

    task automatic test_deferred();
        drive_cfg(2, 1'b1, 1'b1, 10'h3FF, 10'h3FF, 4'd3, 4'd7, 9'd100, 10'd5);
        tick();
        cfg_valid = 1'b0;
        checks++; if (cfg_ready !== 1'b0) $display("FAIL defer_ready_ch2 got %b exp 0", cfg_ready); else passes++;
        cfg_ch = 2'd1;
        #1;
        checks++; if (cfg_ready !== 1'b1) $display("FAIL defer_ready_ch1 got %b exp 1", cfg_ready); else passes++;
        tick(); tick(); tick();
        checks++; if (idx_of(code_idx, 2) !== 10'd0 || chip_stb[2] !== 1'b0) $display("FAIL defer_hold idx=%0d stb=%b exp 0/0", idx_of(code_idx, 2), chip_stb[2]); else passes++;
        sync_in = 1'b1;
        tick();
        sync_in = 1'b0;
        cfg_ch = 2'd2;
        #1;
        checks++; if (idx_of(code_idx, 2) !== 10'd5 || chip_stb[2] !== 1'b0) $display("FAIL defer_apply idx=%0d stb=%b exp 5/0", idx_of(code_idx, 2), chip_stb[2]); else passes++;
        checks++; if (cfg_ready !== 1'b1 || idx_of(code_idx, 1) !== 10'd0) $display("FAIL defer_release ready=%b idx1=%0d exp 1/0", cfg_ready, idx_of(code_idx, 1)); else passes++;
        for (int i = 1; i <= 5; i++) tick();
        checks++; if (idx_of(code_idx, 2) !== 10'd5 || chip_stb[2] !== 1'b0) $display("FAIL defer_nco5 idx=%0d stb=%b exp 5/0", idx_of(code_idx, 2), chip_stb[2]); else passes++;
        tick();
        checks++; if (idx_of(code_idx, 2) !== 10'd6 || chip_stb[2] !== 1'b1 || chip_e[2] !== 1'b1) $display("FAIL defer_nco6 idx=%0d stb=%b e=%b exp 6/1/1", idx_of(code_idx, 2), chip_stb[2], chip_e[2]); else passes++;
        sync_in = 1'b1;
        tick();
        sync_in = 1'b0;
        tick(); tick(); tick();
        checks++; if (idx_of(code_idx, 2) !== 10'd6 || chip_stb[2] !== 1'b0) $display("FAIL idle_sync10 idx=%0d stb=%b exp 6/0", idx_of(code_idx, 2), chip_stb[2]); else passes++;
        tick();
        checks++; if (idx_of(code_idx, 2) !== 10'd7 || chip_stb[2] !== 1'b1) $display("FAIL idle_sync11 idx=%0d stb=%b exp 7/1", idx_of(code_idx, 2), chip_stb[2]); else passes++;
        // Transfer coinciding with sync waits for the following sync
        drive_cfg(3, 1'b1, 1'b1, 10'h3FF, 10'h3FF, 4'd2, 4'd6, 9'd256, 10'd9);
        sync_in = 1'b1;
        tick();
        cfg_valid = 1'b0;
        sync_in = 1'b0;
        #1;
        checks++; if (cfg_ready !== 1'b0 || idx_of(code_idx, 3) !== 10'd0) $display("FAIL sync_same ready=%b idx3=%0d exp 0/0", cfg_ready, idx_of(code_idx, 3)); else passes++;
        tick();
        sync_in = 1'b1;
        tick();
        sync_in = 1'b0;
        #1;
        checks++; if (idx_of(code_idx, 3) !== 10'd9 || cfg_ready !== 1'b1) $display("FAIL sync_next idx3=%0d ready=%b exp 9/1", idx_of(code_idx, 3), cfg_ready); else passes++;
        drive_cfg(3, 1'b1, 1'b1, 10'h3FF, 10'h3FF, 4'd2, 4'd6, 9'd256, 10'd20);
        tick();
        cfg_valid = 1'b0;
        checks++; if (cfg_ready !== 1'b0) $display("FAIL repend_ready got %b exp 0", cfg_ready); else passes++;
    endtask

    task automatic test_collision();
        drive_cfg(0, 1'b0, 1'b1, 10'h3FF, 10'h3FF, 4'd2, 4'd6, 9'd256, 10'd0);
        tick();
        cfg_valid = 1'b0;
        tick();
        drive_cfg(0, 1'b0, 1'b1, 10'h3FF, 10'h3FF, 4'd2, 4'd6, 9'd256, 10'd7);
        tick();
        cfg_valid = 1'b0;
        checks++; if (chip_stb[0] !== 1'b0 || idx_of(code_idx, 0) !== 10'd7 || chip_e[0] !== 1'b0 || chip_p[0] !== 1'b0) $display("FAIL collide_load stb=%b idx=%0d e=%b p=%b exp 0/7/0/0", chip_stb[0], idx_of(code_idx, 0), chip_e[0], chip_p[0]); else passes++;
        tick();
        checks++; if (chip_stb[0] !== 1'b0) $display("FAIL collide_acc_cleared stb=%b exp 0", chip_stb[0]); else passes++;
        tick();
        checks++; if (chip_stb[0] !== 1'b1 || idx_of(code_idx, 0) !== 10'd8 || chip_e[0] !== 1'b1) $display("FAIL collide_resume stb=%b idx=%0d e=%b exp 1/8/1", chip_stb[0], idx_of(code_idx, 0), chip_e[0]); else passes++;
    endtask

    task automatic test_async_reset();
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        checks++; if (chip_stb !== 4'h0 || chip_e !== 4'h0 || chip_p !== 4'h0 || chip_l !== 4'h0 || epoch !== 4'h0) $display("FAIL areset_bits stb=%h e=%h p=%h l=%h ep=%h exp 0", chip_stb, chip_e, chip_p, chip_l, epoch); else passes++;
        checks++; if (code_idx !== '0 || cfg_err !== 1'b0 || cfg_ready !== 1'b0) $display("FAIL areset_idx idx=%h err=%b ready=%b exp 0", code_idx, cfg_err, cfg_ready); else passes++;
        #2 rst = 1'b1;
        tick();
        cfg_ch = 2'd3;
        #1;
        checks++; if (cfg_ready !== 1'b1) $display("FAIL areset_pending_cleared ready=%b exp 1", cfg_ready); else passes++;
        sync_in = 1'b1;
        tick();
        sync_in = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++; if (chip_stb !== 4'h0 || code_idx !== '0) $display("FAIL areset_quiet i=%0d stb=%h idx=%h exp 0", i, chip_stb, code_idx); else passes++;
        end
        drive_cfg(1, 1'b0, 1'b1, 10'h3FF, 10'h3FF, 4'd2, 4'd6, 9'd256, 10'd0);
        tick();
        cfg_valid = 1'b0;
        tick();
        tick();
        checks++; if (chip_stb !== 4'b0010 || idx_of(code_idx, 1) !== 10'd1 || chip_e[1] !== 1'b1) $display("FAIL areset_reload stb=%b idx1=%0d e=%b exp 0010/1/1", chip_stb, idx_of(code_idx, 1), chip_e[1]); else passes++;
    endtask

    initial begin
        rst       = 1'b0;
        cfg_valid = 1'b0;
        cfg_ch    = '0;
        cfg_defer = 1'b0;
        cfg_en    = 1'b0;
        cfg_g1    = '0;
        cfg_g2    = '0;
        cfg_t0    = '0;
        cfg_t1    = '0;
        cfg_omega = '0;
        cfg_idx   = '0;
        sync_in   = 1'b0;
        test_reset();
        test_prn1();
        test_epoch();
        test_invalid();
        test_deferred();
        test_collision();
        test_async_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
